riscv_test_monitor: RTL

- Synthesizable test-status monitor for riscv-tests runs on minisoc.
- Snoops the core's register-file write-back port and keeps shadow copies of the test-number and signature registers.
- Evaluates the PASS/FAIL signature at a programmable interval and flags a timeout after a programmable cycle budget.
- Drives sticky status outputs for the bench, the GPIO LEDs or a board-level indicator.

---
 rtl/riscv_test_monitor.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/riscv_test_monitor.sv
// riscv-tests status monitor: shadows test-number/signature registers from write-back,
// evaluates PASS/FAIL at a fixed interval and flags a cycle-budget timeout.
// Optional tohost decode: define RISCV_TEST_MONITOR_TOHOST_EN.
module riscv_test_monitor #(
  parameter int              XLEN           = 32,
  parameter int              CNT_W          = 32,
  parameter int              TIMEOUT_CYCLES = 1000,
  parameter int              CHECK_INTERVAL = 100,
  parameter int              TEST_NUM_REG   = 3,
  parameter int              SIG1_REG       = 28,
  parameter int              SIG2_REG       = 29,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = 32'h0000_1000
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             restart,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             mem_wr,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [XLEN-1:0]  test_num,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [4:0]       NUM_IDX  = 5'(TEST_NUM_REG);
  localparam logic [4:0]       SIG1_IDX = 5'(SIG1_REG);
  localparam logic [4:0]       SIG2_IDX = 5'(SIG2_REG);
  localparam logic [XLEN-1:0]  X_ZERO   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  X_ONE    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] C_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(CHECK_INTERVAL - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_r, state_nxt_s;
  logic [XLEN-1:0]  sh_num_r, sh_sig1_r, sh_sig2_r;
  logic [CNT_W-1:0] int_cnt_r;
  logic [CNT_W-1:0] int_cnt_nxt_s, cycle_cnt_nxt_s;
  logic [XLEN-1:0]  test_num_nxt_s;
  logic             done_nxt_s, pass_nxt_s, fail_nxt_s, timeout_nxt_s;
  logic             hit_num_s, hit_sig1_s, hit_sig2_s;
  logic             wrap_s, pass_c_s, fail_c_s, tmo_s, stay_run_s;
  logic             th_pass_s, th_fail_s;
  logic [XLEN-1:0]  th_num_s;

  // x0 is hardwired zero in the core, so writes to it never reach a shadow
  assign hit_num_s  = wb_valid && (wb_rd != 5'd0) && (wb_rd == NUM_IDX);
  assign hit_sig1_s = wb_valid && (wb_rd != 5'd0) && (wb_rd == SIG1_IDX);
  assign hit_sig2_s = wb_valid && (wb_rd != 5'd0) && (wb_rd == SIG2_IDX);

  assign wrap_s   = (int_cnt_r == INT_LAST);
  assign pass_c_s = wrap_s && (sh_sig1_r == X_ONE) && (sh_sig2_r == X_ONE);
  assign fail_c_s = wrap_s && (sh_sig1_r == X_ONE) && (sh_sig2_r == X_ZERO);
  assign tmo_s    = (cycle_count == TMO_LAST);

`ifdef RISCV_TEST_MONITOR_TOHOST_EN
  logic tohost_hit_s;
  assign tohost_hit_s = mem_wr && (mem_addr == TOHOST_ADDR);
  assign th_pass_s    = tohost_hit_s && (mem_wdata == X_ONE);
  assign th_fail_s    = tohost_hit_s && mem_wdata[0] && (mem_wdata != X_ONE);
  assign th_num_s     = mem_wdata >> 1;
`else
  logic unused_mem_s;
  assign unused_mem_s = ^{mem_wr, mem_addr, mem_wdata};
  assign th_pass_s    = 1'b0;
  assign th_fail_s    = 1'b0;
  assign th_num_s     = X_ZERO;
`endif

  // State register; reset and restart both return to RUN
  always_ff @(posedge clk) begin
    if (!rst_b || restart) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decision: tohost, then signature, then timeout
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (th_pass_s) begin
          state_nxt_s = ST_PASS;
        end else if (th_fail_s) begin
          state_nxt_s = ST_FAIL;
        end else if (pass_c_s) begin
          state_nxt_s = ST_PASS;
        end else if (fail_c_s) begin
          state_nxt_s = ST_FAIL;
        end else if (tmo_s) begin
          state_nxt_s = ST_TIMEOUT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_PASS:    state_nxt_s = ST_PASS;
      ST_FAIL:    state_nxt_s = ST_FAIL;
      ST_TIMEOUT: state_nxt_s = ST_TIMEOUT;
      default:    state_nxt_s = ST_RUN;
    endcase
  end

  // Output/counter next values; counters stop on the decision cycle itself
  always_comb begin
    stay_run_s      = (state_r == ST_RUN) && (state_nxt_s == ST_RUN);
    done_nxt_s      = (state_nxt_s != ST_RUN);
    pass_nxt_s      = (state_nxt_s == ST_PASS);
    fail_nxt_s      = (state_nxt_s == ST_FAIL);
    timeout_nxt_s   = (state_nxt_s == ST_TIMEOUT);
    cycle_cnt_nxt_s = cycle_count;
    int_cnt_nxt_s   = int_cnt_r;
    test_num_nxt_s  = test_num;
    if (stay_run_s) begin
      if (cycle_count != C_MAX) begin
        cycle_cnt_nxt_s = cycle_count + C_ONE;
      end else begin
        cycle_cnt_nxt_s = cycle_count;
      end
      if (wrap_s) begin
        int_cnt_nxt_s = C_ZERO;
      end else begin
        int_cnt_nxt_s = int_cnt_r + C_ONE;
      end
    end else begin
      cycle_cnt_nxt_s = cycle_count;
      int_cnt_nxt_s   = int_cnt_r;
    end
    if (done) begin
      test_num_nxt_s = test_num;
    end else if (th_fail_s) begin
      test_num_nxt_s = th_num_s;
    end else if (hit_num_s) begin
      test_num_nxt_s = wb_data;
    end else begin
      test_num_nxt_s = test_num;
    end
  end

  // Registered flags, counters and visible test number
  always_ff @(posedge clk) begin
    if (!rst_b || restart) begin
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      test_num    <= X_ZERO;
      cycle_count <= C_ZERO;
      int_cnt_r   <= C_ZERO;
    end else begin
      done        <= done_nxt_s;
      pass        <= pass_nxt_s;
      fail        <= fail_nxt_s;
      timeout     <= timeout_nxt_s;
      test_num    <= test_num_nxt_s;
      cycle_count <= cycle_cnt_nxt_s;
      int_cnt_r   <= int_cnt_nxt_s;
    end
  end

  // Shadow registers track write-back in every state
  always_ff @(posedge clk) begin
    if (!rst_b || restart) begin
      sh_num_r  <= X_ZERO;
      sh_sig1_r <= X_ZERO;
      sh_sig2_r <= X_ZERO;
    end else begin
      if (hit_num_s) begin
        sh_num_r <= wb_data;
      end
      if (hit_sig1_s) begin
        sh_sig1_r <= wb_data;
      end
      if (hit_sig2_s) begin
        sh_sig2_r <= wb_data;
      end
    end
  end

endmodule
